// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the fetch sequencer's control inputs (run/halt/step, stall, jump)
// and its fetch-side outputs (ROM address, valid/PC tag, debug status).
//
// Modports:
//   master - the fetch sequencer: consumes control, drives ROM address/tags.
//   slave  - the surrounding logic (hazard/branch unit, debugger, consumer):
//            drives control, observes ROM address/tags.
//
// Signals:
//   run_en, halt_req, step_req  debug run/halt/single-step control
//   stall                       downstream cannot accept an instruction
//   jump_flag, jump_addr        one-cycle redirect request and target
//   rom_addr                    combinational ROM read address
//   instr_valid, instr_pc       registered tag for the word on ROM douta
//   pc                          registered next-fetch address
//   halted                      sequencer is idle or halted
//   fetch_count                 count of issued fetches (wraps)
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int Addr_B = 10,
  parameter int CNT_B  = 32
);
  logic              run_en;
  logic              halt_req;
  logic              step_req;
  logic              stall;
  logic              jump_flag;
  logic [Addr_B-1:0] jump_addr;
  logic [Addr_B-1:0] rom_addr;
  logic              instr_valid;
  logic [Addr_B-1:0] instr_pc;
  logic [Addr_B-1:0] pc;
  logic              halted;
  logic [CNT_B-1:0]  fetch_count;

  modport master (
    input  run_en, halt_req, step_req, stall, jump_flag, jump_addr,
    output rom_addr, instr_valid, instr_pc, pc, halted, fetch_count
  );

  modport slave (
    output run_en, halt_req, step_req, stall, jump_flag, jump_addr,
    input  rom_addr, instr_valid, instr_pc, pc, halted, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter of the fetch stage and drives the synchronous
// instruction ROM address. Because the ROM has one cycle of read latency, the
// sequencer tags the word appearing on douta with a registered valid bit and
// the address it was read from. Supports stalls, zero-bubble jump redirects
// and debug run / halt / single-step control.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    fetch_sequencer_if.master (control in, ROM address/tags out)
//
// Parameters:
//   width_B  instruction word width (carried for the stage, unused here)
//   Addr_B   ROM address / PC width
//   CNT_B    issued-fetch counter width
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int width_B = 32,
  parameter int Addr_B  = 10,
  parameter int CNT_B   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_sequencer_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } state_t;

  localparam logic [Addr_B-1:0] ADDR_ONE = Addr_B'(1);
  localparam logic [CNT_B-1:0]  CNT_ONE  = CNT_B'(1);

  state_t            state_r;
  state_t            state_nx_s;
  logic [Addr_B-1:0] pc_r;
  logic [Addr_B-1:0] instr_pc_r;
  logic              instr_valid_r;
  logic [CNT_B-1:0]  fetch_count_r;

  logic              fetching_s;
  logic              jump_issue_s;
  logic              issue_s;
  logic              fire_s;
  logic              pc_load_s;
  logic              halted_s;
  logic [Addr_B-1:0] rom_addr_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; halt_req always outranks run_en, and STEP leaves only
  // once its single issue (normal or jump) has actually happened.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.run_en && !bus.halt_req) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          state_nx_s = HALT;
        end else begin
          state_nx_s = RUN;
        end
      end
      HALT: begin
        if (bus.halt_req) begin
          state_nx_s = HALT;
        end else if (bus.run_en) begin
          state_nx_s = RUN;
        end else if (bus.step_req) begin
          state_nx_s = STEP;
        end else begin
          state_nx_s = HALT;
        end
      end
      STEP: begin
        if (fire_s) begin
          state_nx_s = HALT;
        end else begin
          state_nx_s = STEP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Output/issue decode. With no issue the ROM is pointed back at instr_pc so
  // douta keeps presenting the same word (needed to hold it across a stall).
  always_comb begin
    fetching_s   = (state_r == RUN) || (state_r == STEP);
    jump_issue_s = fetching_s && bus.jump_flag;
    issue_s      = fetching_s && !bus.stall && !((state_r == RUN) && bus.halt_req);
    fire_s       = jump_issue_s || issue_s;
    pc_load_s    = !fetching_s && bus.jump_flag;
    halted_s     = !fetching_s;
    if (jump_issue_s) begin
      rom_addr_s = bus.jump_addr;
    end else if (issue_s) begin
      rom_addr_s = pc_r;
    end else begin
      rom_addr_s = instr_pc_r;
    end
  end

  // PC, fetch tag and issue counter. A jump issues its target immediately,
  // so the following fetch is target+1 and no bubble appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= '0;
      instr_pc_r    <= '0;
      instr_valid_r <= 1'b0;
      fetch_count_r <= '0;
    end else if (jump_issue_s) begin
      pc_r          <= bus.jump_addr + ADDR_ONE;
      instr_pc_r    <= bus.jump_addr;
      instr_valid_r <= 1'b1;
      fetch_count_r <= fetch_count_r + CNT_ONE;
    end else if (issue_s) begin
      pc_r          <= pc_r + ADDR_ONE;
      instr_pc_r    <= pc_r;
      instr_valid_r <= 1'b1;
      fetch_count_r <= fetch_count_r + CNT_ONE;
    end else if (pc_load_s) begin
      // Debugger PC load while idle/halted: nothing is fetched.
      pc_r          <= bus.jump_addr;
      instr_pc_r    <= instr_pc_r;
      instr_valid_r <= 1'b0;
      fetch_count_r <= fetch_count_r;
    end else begin
      pc_r          <= pc_r;
      instr_pc_r    <= instr_pc_r;
      instr_valid_r <= bus.stall ? instr_valid_r : 1'b0;
      fetch_count_r <= fetch_count_r;
    end
  end

  assign bus.rom_addr    = rom_addr_s;
  assign bus.instr_valid = instr_valid_r;
  assign bus.instr_pc    = instr_pc_r;
  assign bus.pc          = pc_r;
  assign bus.halted      = halted_s;
  assign bus.fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Scoreboard bench: every cycle in which a fetch is expected, the expected
// address is pushed to a queue; after the next edge it is popped and compared
// against the tagged instr_pc. PC and fetch count are tracked by a small model.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int AW = 10;
  localparam int CW = 32;

  logic clk;
  logic reset;

  fetch_sequencer_if #(.Addr_B(AW), .CNT_B(CW)) bus ();

  fetch_sequencer #(.width_B(32), .Addr_B(AW), .CNT_B(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks_cnt;
  int errors_cnt;

  logic [AW-1:0] sb_q[$];
  logic [AW-1:0] m_pc;
  logic [CW-1:0] m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // One clock cycle with inputs already set: check the combinational ROM
  // address, push an expected fetch if one should issue, then after the edge
  // pop it and check the tag, PC and fetch count.
  task automatic tick(input bit exp_issue, input logic [AW-1:0] exp_addr);
    logic [AW-1:0] want;
    #1;
    check_val("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
    if (exp_issue) begin
      sb_q.push_back(exp_addr);
      m_pc  = exp_addr + 10'd1;
      m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    if (exp_issue) begin
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 32'd0, 32'd1);
      end else begin
        want = sb_q.pop_front();
        check_val("instr_pc", 32'(bus.instr_pc), 32'(want));
        check_val("instr_valid", 32'(bus.instr_valid), 32'd1);
      end
    end
    check_val("pc", 32'(bus.pc), 32'(m_pc));
    check_val("fetch_count", bus.fetch_count, m_cnt);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    m_pc  = 10'd0;
    m_cnt = 32'd0;
    reset = 1'b1;
    bus.run_en    = 1'b0;
    bus.halt_req  = 1'b0;
    bus.step_req  = 1'b0;
    bus.stall     = 1'b0;
    bus.jump_flag = 1'b0;
    bus.jump_addr = 10'd0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_val("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check_val("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_val("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    check_val("rst_pc", 32'(bus.pc), 32'd0);
    check_val("rst_count", bus.fetch_count, 32'd0);
    check_val("rst_halted", 32'(bus.halted), 32'd1);
    @(posedge clk);
    #1;

    // Leave IDLE, then free-run 0..7.
    bus.run_en = 1'b1;
    tick(1'b0, 10'd0);
    check_val("run_halted", 32'(bus.halted), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 10'(i));
      if (i == 4) check_val("count_after5", bus.fetch_count, 32'd5);
    end

    // Stall for 3 cycles with instr_pc = 7: douta held, valid held.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 10'd7);
      check_val("stall_valid", 32'(bus.instr_valid), 32'd1);
      check_val("stall_ipc", 32'(bus.instr_pc), 32'd7);
    end
    bus.stall = 1'b0;
    tick(1'b1, 10'd8);

    // Jump wins over a simultaneous stall; next fetch follows with no bubble.
    bus.jump_flag = 1'b1;
    bus.jump_addr = 10'h3F0;
    bus.stall     = 1'b1;
    tick(1'b1, 10'h3F0);
    bus.jump_flag = 1'b0;
    bus.stall     = 1'b0;
    tick(1'b1, 10'h3F1);

    // Jump to the top address and wrap through zero.
    bus.jump_flag = 1'b1;
    bus.jump_addr = 10'h3FF;
    tick(1'b1, 10'h3FF);
    check_val("wrap_pc", 32'(bus.pc), 32'd0);
    bus.jump_flag = 1'b0;
    tick(1'b1, 10'h000);
    tick(1'b1, 10'h001);

    // Get to pc = 12, then halt.
    bus.jump_flag = 1'b1;
    bus.jump_addr = 10'd11;
    tick(1'b1, 10'd11);
    bus.jump_flag = 1'b0;
    bus.halt_req  = 1'b1;
    tick(1'b0, 10'd11);
    check_val("halt_halted", 32'(bus.halted), 32'd1);
    check_val("halt_valid", 32'(bus.instr_valid), 32'd0);

    // Two single steps: 12 then 13, each valid for exactly one cycle.
    bus.halt_req = 1'b0;
    bus.run_en   = 1'b0;
    bus.step_req = 1'b1;
    tick(1'b0, 10'd11);
    bus.step_req = 1'b0;
    tick(1'b1, 10'd12);
    bus.step_req = 1'b1;
    tick(1'b0, 10'd12);
    check_val("step1_drop", 32'(bus.instr_valid), 32'd0);
    bus.step_req = 1'b0;
    tick(1'b1, 10'd13);
    tick(1'b0, 10'd13);
    check_val("step2_drop", 32'(bus.instr_valid), 32'd0);
    check_val("step_halted", 32'(bus.halted), 32'd1);

    // A stalled step waits in STEP until the stall clears.
    bus.step_req = 1'b1;
    tick(1'b0, 10'd13);
    bus.step_req = 1'b0;
    bus.stall    = 1'b1;
    tick(1'b0, 10'd13);
    bus.stall = 1'b0;
    tick(1'b1, 10'd14);
    tick(1'b0, 10'd14);
    check_val("stepst_halted", 32'(bus.halted), 32'd1);

    // Debugger PC load while halted: no fetch, valid stays low.
    bus.jump_flag = 1'b1;
    bus.jump_addr = 10'h100;
    m_pc = 10'h100;
    tick(1'b0, 10'd14);
    check_val("load_valid", 32'(bus.instr_valid), 32'd0);
    bus.jump_flag = 1'b0;

    // halt_req beats run_en; then resume from the loaded PC.
    bus.run_en   = 1'b1;
    bus.halt_req = 1'b1;
    tick(1'b0, 10'd14);
    check_val("halt_prio", 32'(bus.halted), 32'd1);
    bus.halt_req = 1'b0;
    tick(1'b0, 10'd14);
    tick(1'b1, 10'h100);
    tick(1'b1, 10'h101);

    // Asynchronous reset in the middle of a stalled RUN cycle.
    bus.stall = 1'b1;
    tick(1'b0, 10'h101);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check_val("arst_valid", 32'(bus.instr_valid), 32'd0);
    check_val("arst_instr_pc", 32'(bus.instr_pc), 32'd0);
    check_val("arst_pc", 32'(bus.pc), 32'd0);
    check_val("arst_count", bus.fetch_count, 32'd0);
    check_val("arst_halted", 32'(bus.halted), 32'd1);
    #2;
    reset = 1'b0;
    bus.stall  = 1'b0;
    bus.run_en = 1'b0;

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
